// File: rtl/mem_io_responder_pkg.sv
// Shared bus encodings and I/O window addresses for the memory/IO responder.
package mem_io_responder_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // addr[17:16] value that selects the I/O window instead of RAM.
  localparam logic [1:0] IO_REGION = 2'b11;

  // Decoded 18-bit I/O register addresses.
  localparam logic [17:0] IO_UART_DATA   = 18'h30000;
  localparam logic [17:0] IO_STATUS_HALT = 18'h30004;

  // Which register drives mem_rdata after an edge.
  typedef enum logic {
    RD_REG = 1'b0,
    RD_RAM = 1'b1
  } rd_src_t;

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with drop-on-full push and ignore-on-empty pop.
// DEPTH must be a power of two (pointers wrap naturally), at least 2.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle never makes room for a push when full.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory bus target: RAM plus an I/O window holding UART TX/RX
// FIFOs, a status register and a sticky halt flag. Every cycle is a bus
// transaction; read data appears one edge after the request.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        halt
);

  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic [17:0] dec_addr;
  logic        io_sel;
  logic        is_wr;
  logic        ram_we;
  logic        ram_rd;
  logic        tx_push;
  logic        halt_set;
  logic        rx_pop;
  logic        status_rd;

  logic        tx_full;
  logic        tx_empty;
  logic        rx_empty;
  logic [7:0]  rx_dout;
  logic [7:0]  io_rdata;
  logic [7:0]  io_rdata_q;
  logic [7:0]  ram_rd_q;
  rd_src_t     rd_src_q;

  logic [7:0]     ram [2**ADDR_W];
  logic [TCW-1:0] unused_tx_count;
  logic [RCW-1:0] unused_rx_count;
  logic           unused_rx_full;
  logic           unused_addr_hi;

  assign unused_addr_hi = ^mem_addr[31:18];

  assign dec_addr  = mem_addr[17:0];
  assign io_sel    = (dec_addr[17:16] == IO_REGION);
  assign is_wr     = (mem_wr == MEM_WRITE);
  assign ram_we    = !io_sel && is_wr;
  assign ram_rd    = !io_sel && !is_wr;
  assign tx_push   = io_sel && is_wr  && (dec_addr == IO_UART_DATA);
  assign halt_set  = io_sel && is_wr  && (dec_addr == IO_STATUS_HALT);
  assign rx_pop    = io_sel && !is_wr && (dec_addr == IO_UART_DATA);
  assign status_rd = io_sel && !is_wr && (dec_addr == IO_STATUS_HALT);

  // TX handshake: tx_data is held stable while tx_valid is high and is
  // consumed on any edge where tx_valid && tx_ready; neither side waits on
  // the other combinationally.
  assign tx_valid       = !tx_empty;
  assign io_buffer_full = tx_full;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (mem_wdata),
    .pop   (tx_ready),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (unused_tx_count)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .full  (unused_rx_full),
    .empty (rx_empty),
    .count (unused_rx_count)
  );

  // RAM array with a registered read port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) ram[mem_addr[ADDR_W-1:0]] <= mem_wdata;
    ram_rd_q <= ram[mem_addr[ADDR_W-1:0]];
  end

  // Read value for I/O accesses; zero for writes and unmapped registers.
  always_comb begin
    io_rdata = 8'h00;
    if (rx_pop && !rx_empty) begin
      io_rdata = rx_dout;
    end else if (status_rd) begin
      io_rdata = {6'b0, tx_full, !rx_empty};
    end
  end

  // Read-source select and I/O read register; reset forces mem_rdata to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_src_q   <= RD_REG;
      io_rdata_q <= 8'h00;
    end else begin
      rd_src_q   <= ram_rd ? RD_RAM : RD_REG;
      io_rdata_q <= io_rdata;
    end
  end

  assign mem_rdata = (rd_src_q == RD_RAM) ? ram_rd_q : io_rdata_q;

  // Sticky program-end flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt <= 1'b0;
    end else if (halt_set) begin
      halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: a driver issues one bus transaction per cycle
// and updates a queue-based reference model; a monitor compares the DUT
// against the expected queue half a cycle after each edge.
module tb_mem_io_responder;

  localparam int W = 12;  // {rdata_dont_care, halt, tx_valid, full, rdata[7:0]}

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        halt;

  logic [W-1:0] exp_q[$];
  logic [7:0]   tx_exp_q[$];

  logic [7:0] ram_m [int];
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  logic       halt_m;

  int n_checks;
  int n_pass;
  int pool[16];

  mem_io_responder dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .halt           (halt)
  );

  // Clock and reset-time defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%02h exp=%02h at %0t", name, got, want, $time);
  endtask

  // One bus cycle: apply inputs, advance the model across the coming edge,
  // queue the expected post-edge outputs, then wait past the edge.
  task automatic cycle(input logic r, input logic [31:0] a, input logic w,
                       input logic [7:0] d, input logic txr,
                       input logic rxv, input logic [7:0] rxd);
    logic [17:0] a18;
    logic [7:0]  exp_rd;
    logic        dc;
    int          txn;
    int          rxn;
    rst = r; mem_addr = a; mem_wr = w; mem_wdata = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    a18 = a[17:0];
    exp_rd = 8'h00;
    dc = 1'b0;
    txn = tx_m.size();
    rxn = rx_m.size();
    if (r) begin
      tx_m.delete(); rx_m.delete(); tx_exp_q.delete();
      halt_m = 1'b0;
    end else begin
      if (a18[17:16] != 2'b11) begin
        if (w) ram_m[int'(a18[16:0])] = d;
        else if (ram_m.exists(int'(a18[16:0]))) exp_rd = ram_m[int'(a18[16:0])];
        else dc = 1'b1;
      end else if (w) begin
        if (a18 == 18'h30004) halt_m = 1'b1;
      end else begin
        if (a18 == 18'h30000) begin
          if (rxn > 0) exp_rd = rx_m.pop_front();
        end else if (a18 == 18'h30004) begin
          exp_rd = {6'b0, txn == 8, rxn != 0};
        end
      end
      if (txn > 0 && txr) void'(tx_m.pop_front());
      if (w && a18 == 18'h30000 && txn < 8) begin
        tx_m.push_back(d);
        tx_exp_q.push_back(d);
      end
      if (rxv && rxn < 8) rx_m.push_back(rxd);
    end
    exp_q.push_back({dc, halt_m, tx_m.size() != 0, tx_m.size() == 8, exp_rd});
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic txr);
    cycle(1'b0, 32'h0, 1'b0, 8'h00, txr, 1'b0, 8'h00);
  endtask

  task automatic ram_wr(input logic [31:0] a, input logic [7:0] d, input logic txr);
    cycle(1'b0, a, 1'b1, d, txr, 1'b0, 8'h00);
  endtask

  task automatic ram_rd(input logic [31:0] a, input logic txr);
    cycle(1'b0, a, 1'b0, 8'h00, txr, 1'b0, 8'h00);
  endtask

  task automatic reset_cycle();
    cycle(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  function automatic logic [31:0] pool_addr(input int idx);
    logic [16:0] low;
    logic        b17;
    low = 17'(idx);
    b17 = low[16] ? 1'b0 : 1'($urandom_range(0, 1));
    return {14'($urandom_range(0, 16383)), b17, low};
  endfunction

  // Monitor: half a cycle after each edge, pop and compare the expected state,
  // and check any TX byte about to be consumed on the next edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!e[11]) chk("rdata", mem_rdata, e[7:0]);
      chk("io_buffer_full", {7'b0, io_buffer_full}, {7'b0, e[8]});
      chk("tx_valid", {7'b0, tx_valid}, {7'b0, e[9]});
      chk("halt", {7'b0, halt}, {7'b0, e[10]});
    end
    if (!rst && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (tx_exp_q.size() == 0) chk("tx_spurious", tx_data, 8'hxx);
      else chk("tx_data", tx_data, tx_exp_q.pop_front());
    end
  end

  // Driver: directed scenarios first, then randomized traffic.
  initial begin
    n_checks = 0; n_pass = 0; halt_m = 1'b0;
    rst = 1'b1; mem_addr = '0; mem_wr = 1'b0; mem_wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #1;
    reset_cycle(); reset_cycle();

    // Seed a pool of RAM locations (including the idle address 0).
    pool[0] = 0;
    for (int i = 1; i < 16; i++) pool[i] = int'($urandom_range(0, 131071));
    for (int i = 0; i < 16; i++) ram_wr(pool_addr(pool[i]), 8'($urandom), 1'b0);

    // RAM write then read with one-cycle latency.
    ram_wr(32'h0001_2345, 8'hA5, 1'b0);
    ram_rd(32'h0001_2345, 1'b0);
    idle(1'b0);

    // TX fill to full, overflow dropped, then drain.
    for (int i = 1; i <= 8; i++) ram_wr(32'h0003_0000, 8'(i), 1'b0);
    ram_wr(32'h0003_0000, 8'h99, 1'b0);
    for (int i = 0; i < 9; i++) idle(1'b1);

    // Simultaneous push and pop at count 3.
    for (int i = 0; i < 3; i++) ram_wr(32'h0003_0000, 8'hA1 + 8'(i), 1'b0);
    ram_wr(32'h0003_0000, 8'h42, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // RX path: two bytes in, status, three data reads, status.
    cycle(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h61);
    cycle(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h62);
    ram_rd(32'h0003_0004, 1'b0);
    ram_rd(32'h0003_0000, 1'b0);
    ram_rd(32'h0003_0000, 1'b0);
    ram_rd(32'h0003_0000, 1'b0);
    ram_rd(32'h0003_0004, 1'b0);

    // Halt is sticky until reset.
    ram_wr(32'h0003_0004, 8'h5A, 1'b0);
    ram_wr(32'h0000_0100, 8'h11, 1'b0);
    ram_rd(32'h0000_0100, 1'b0);
    ram_wr(32'h0003_0000, 8'h77, 1'b0);
    reset_cycle();
    idle(1'b0);

    // Reset mid-stream: TX contents lost, RAM kept.
    for (int i = 0; i < 4; i++) ram_wr(32'h0003_0000, 8'hC0 + 8'(i), 1'b0);
    ram_wr(32'h0000_0777, 8'h3C, 1'b0);
    reset_cycle();
    idle(1'b0);
    ram_rd(32'h0000_0777, 1'b0);
    idle(1'b0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      int          op;
      logic        txr;
      logic        rxv;
      logic [13:0] hi;
      op  = int'($urandom_range(0, 99));
      txr = 1'($urandom_range(0, 1));
      rxv = ($urandom_range(0, 9) < 3);
      hi  = 14'($urandom_range(0, 16383));
      if (op < 20)
        cycle(1'b0, pool_addr(pool[$urandom_range(0, 15)]), 1'b1, 8'($urandom), txr, rxv, 8'($urandom));
      else if (op < 42)
        cycle(1'b0, pool_addr(pool[$urandom_range(0, 15)]), 1'b0, 8'($urandom), txr, rxv, 8'($urandom));
      else if (op < 60)
        cycle(1'b0, {hi, 18'h30000}, 1'b1, 8'($urandom), txr, rxv, 8'($urandom));
      else if (op < 72)
        cycle(1'b0, {hi, 18'h30000}, 1'b0, 8'($urandom), txr, rxv, 8'($urandom));
      else if (op < 80)
        cycle(1'b0, {hi, 18'h30004}, 1'b0, 8'($urandom), txr, rxv, 8'($urandom));
      else if (op < 85)
        cycle(1'b0, {hi, 18'h30008}, 1'b0, 8'($urandom), txr, rxv, 8'($urandom));
      else if (op < 89)
        cycle(1'b0, {hi, 18'h3000C}, 1'b1, 8'($urandom), txr, rxv, 8'($urandom));
      else if (op < 90)
        cycle(1'b0, {hi, 18'h30004}, 1'b1, 8'($urandom), txr, rxv, 8'($urandom));
      else if (op < 91)
        reset_cycle();
      else
        cycle(1'b0, 32'h0, 1'b0, 8'h00, txr, rxv, 8'($urandom));
    end

    #3;
    chk("exp_q_drained", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
